rv32_operand_bypass: RTL and testbench
======================================

Name: rv32_operand_bypass

Overview:
- Decode→execute operand stage, directly downstream of the register file.
- Takes the register-file read values and applies EX/MEM/WB bypassing to them. Detects load-use hazards and registers operands plus destination control into the execute stage.
- Inserts bubbles on load-use and honours pipeline stall/flush.

Parameters:
XLEN, 32, datapath width of operand values and forwarded results.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
stall_in  input  1  downstream stall; hold all registered outputs
flush_in  input  1  squash instruction entering execute
valid_in  input  1  decode-stage instruction valid
rs1_in  input  5  decode rs1 index
rs2_in  input  5  decode rs2 index
rs1_used_in  input  1  instruction reads rs1
rs2_used_in  input  1  instruction reads rs2
rd_in  input  5  decode destination index
rd_write_in  input  1  decode writes rd
rs1_value_in  input  XLEN  register-file rs1 read value
rs2_value_in  input  XLEN  register-file rs2 read value
ex_valid_in  input  1  execute-stage instruction valid
ex_rd_in  input  5  execute destination
ex_rd_write_in  input  1  execute writes rd
ex_mem_read_in  input  1  execute instruction is a load
ex_result_in  input  XLEN  execute ALU result
mem_valid_in  input  1  memory-stage valid
mem_rd_in  input  5  memory destination
mem_rd_write_in  input  1  memory writes rd
mem_result_in  input  XLEN  memory-stage result (load data resolved)
wb_rd_in  input  5  writeback destination (same as regfile rd_in)
wb_rd_write_in  input  1  writeback write enable
wb_flush_in  input  1  writeback squash (same as regfile writeback_flush_in)
wb_result_in  input  XLEN  writeback value
stall_out  output  1  hold fetch/decode (and regfile read latch)
valid_out  output  1  execute-stage valid
rs1_value_out  output  XLEN  bypassed rs1 operand
rs2_value_out  output  XLEN  bypassed rs2 operand
rd_out  output  5  execute destination
rd_write_out  output  1  execute write enable

Behaviour:
- Forward select (combinational), evaluated separately for rs1 and rs2:
  - Index 0 is never forwarded; the register-file value is used.
  - Otherwise the first matching source in priority order EX > MEM > WB wins. If none match, the register-file value is used.
  - EX matches when: ex_valid_in, ex_rd_write_in, !ex_mem_read_in, ex_rd_in == index.
  - MEM matches when: mem_valid_in, mem_rd_write_in, mem_rd_in == index.
  - WB matches when: wb_rd_write_in, !wb_flush_in, wb_rd_in == index. The register file commits WB at the same edge, so this path is required.
- load_use (combinational) is asserted when all of the following hold:
  - valid_in, ex_valid_in, ex_mem_read_in, ex_rd_write_in, and ex_rd_in != 0;
  - and either (rs1_used_in and rs1_in == ex_rd_in) or (rs2_used_in and rs2_in == ex_rd_in).
- stall_out = stall_in | load_use. It is combinational with no registered path.
- Registered update at posedge clk, first match wins:
  1. reset: valid_out=0, rd_write_out=0, rd_out=0, rs1_value_out=0, rs2_value_out=0.
  2. stall_in: all outputs hold. Stall has priority over flush and hazard.
  3. flush_in: valid_out=0, rd_write_out=0; other outputs hold.
  4. load_use: bubble — valid_out=0, rd_write_out=0. Upstream holds via stall_out, so the instruction is re-presented next cycle, when the load is in MEM and is forwarded.
  5. otherwise: valid_out=valid_in, rd_write_out=rd_write_in & valid_in, rd_out=rd_in, operands = forwarded values.
- Latency: 1 cycle, decode inputs to execute outputs.
- Reset takes effect mid-stall or mid-hazard without exception. stall_out may be asserted during reset (combinational), which is harmless.
- Simultaneous matches: EX, MEM and WB all targeting the same index → EX value is used.
- An invalid decode instruction (valid_in=0) never raises load_use.

Test Plan:
- Back-to-back ALU dependency: EX writes x5=0x11, decode reads rs1=x5, regfile gives 0 → next cycle rs1_value_out=0x11, valid_out=1, stall_out=0.
- Priority: EX x7=0xA, MEM x7=0xB, WB x7=0xC, decode rs2=x7 → rs2_value_out=0xA. Repeat with EX not matching → 0xB. Repeat with only WB matching → 0xC.
- x0 guard: EX writes x0=0xFFFF_FFFF, decode rs1=x0, regfile value 0 → rs1_value_out=0.
- Load-use: EX is a load to x3, decode rs1=x3 with rs1_used_in=1 → stall_out=1 and valid_out=0 next cycle. Next cycle MEM x3=0x1234 → rs1_value_out=0x1234, valid_out=1. With rs1_used_in=0 there is no stall.
- Stall/flush: stall_in=1 with flush_in=1 → outputs unchanged. stall_in=0 with flush_in=1 → valid_out=0, rd_write_out=0.
- Reset: assert reset mid-hazard with outputs holding 0xDEAD → all outputs 0 next cycle. Deassert → normal capture resumes the following cycle.

Source files
------------

// File: rtl/rv32_operand_bypass.sv
// Decode-to-execute operand stage for an RV32 pipeline.
//
// Takes the register-file read values for rs1/rs2 and replaces them with
// in-flight results from EX, MEM or WB when those stages target the same
// register. Detects a load in EX feeding the decode instruction (load-use),
// holds upstream via stall_out and inserts a bubble into execute. Operands and
// destination control are registered into the execute stage with one cycle of
// latency.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   stall_in, flush_in     downstream stall (hold everything), squash into EX
//   valid_in, rs*/rd*      decode-stage instruction and register-file values
//   ex_*, mem_*, wb_*      forwarding sources from later pipeline stages
//   stall_out              hold fetch/decode and the regfile read latch
//   valid_out, rs*_value_out, rd_out, rd_write_out
//                          registered execute-stage instruction
module rv32_operand_bypass #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            valid_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic            rs1_used_in,
  input  logic            rs2_used_in,
  input  logic [4:0]      rd_in,
  input  logic            rd_write_in,
  input  logic [XLEN-1:0] rs1_value_in,
  input  logic [XLEN-1:0] rs2_value_in,
  input  logic            ex_valid_in,
  input  logic [4:0]      ex_rd_in,
  input  logic            ex_rd_write_in,
  input  logic            ex_mem_read_in,
  input  logic [XLEN-1:0] ex_result_in,
  input  logic            mem_valid_in,
  input  logic [4:0]      mem_rd_in,
  input  logic            mem_rd_write_in,
  input  logic [XLEN-1:0] mem_result_in,
  input  logic [4:0]      wb_rd_in,
  input  logic            wb_rd_write_in,
  input  logic            wb_flush_in,
  input  logic [XLEN-1:0] wb_result_in,
  output logic            stall_out,
  output logic            valid_out,
  output logic [XLEN-1:0] rs1_value_out,
  output logic [XLEN-1:0] rs2_value_out,
  output logic [4:0]      rd_out,
  output logic            rd_write_out
);

  // Source qualifiers independent of the register index. A load in EX has no
  // data yet, so it is never a forwarding source; load-use covers that case.
  logic ex_fwd_ok, mem_fwd_ok, wb_fwd_ok;
  assign ex_fwd_ok  = ex_valid_in & ex_rd_write_in & ~ex_mem_read_in;
  assign mem_fwd_ok = mem_valid_in & mem_rd_write_in;
  // The regfile commits WB on the same edge we sample, so its read value is
  // still stale and WB must be forwarded.
  assign wb_fwd_ok  = wb_rd_write_in & ~wb_flush_in;

  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  always_comb begin
    rs1_fwd = rs1_value_in;
    if (rs1_in != 5'd0) begin
      if (ex_fwd_ok && (ex_rd_in == rs1_in)) begin
        rs1_fwd = ex_result_in;
      end else if (mem_fwd_ok && (mem_rd_in == rs1_in)) begin
        rs1_fwd = mem_result_in;
      end else if (wb_fwd_ok && (wb_rd_in == rs1_in)) begin
        rs1_fwd = wb_result_in;
      end
    end
  end

  always_comb begin
    rs2_fwd = rs2_value_in;
    if (rs2_in != 5'd0) begin
      if (ex_fwd_ok && (ex_rd_in == rs2_in)) begin
        rs2_fwd = ex_result_in;
      end else if (mem_fwd_ok && (mem_rd_in == rs2_in)) begin
        rs2_fwd = mem_result_in;
      end else if (wb_fwd_ok && (wb_rd_in == rs2_in)) begin
        rs2_fwd = wb_result_in;
      end
    end
  end

  logic ex_load_pending;
  logic load_use;
  assign ex_load_pending = ex_valid_in & ex_mem_read_in & ex_rd_write_in & (ex_rd_in != 5'd0);
  assign load_use = valid_in & ex_load_pending &
                    ((rs1_used_in & (rs1_in == ex_rd_in)) |
                     (rs2_used_in & (rs2_in == ex_rd_in)));

  assign stall_out = stall_in | load_use;

  logic            valid_q, valid_d;
  logic            rd_write_q, rd_write_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;

  always_comb begin
    valid_d    = valid_q;
    rd_write_d = rd_write_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    if (stall_in) begin
      // Hold everything; stall outranks flush and the hazard bubble.
    end else if (flush_in || load_use) begin
      valid_d    = 1'b0;
      rd_write_d = 1'b0;
    end else begin
      valid_d    = valid_in;
      rd_write_d = rd_write_in & valid_in;
      rd_d       = rd_in;
      rs1_d      = rs1_fwd;
      rs2_d      = rs2_fwd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      rd_write_q <= 1'b0;
      rd_q       <= 5'd0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      rd_write_q <= rd_write_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
    end
  end

  assign valid_out     = valid_q;
  assign rd_write_out  = rd_write_q;
  assign rd_out        = rd_q;
  assign rs1_value_out = rs1_q;
  assign rs2_value_out = rs2_q;

endmodule

// File: tb/tb_rv32_operand_bypass.sv
module tb_rv32_operand_bypass;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_in, flush_in, valid_in;
  logic [4:0]  rs1_in, rs2_in, rd_in;
  logic        rs1_used_in, rs2_used_in, rd_write_in;
  logic [31:0] rs1_value_in, rs2_value_in;
  logic        ex_valid_in, ex_rd_write_in, ex_mem_read_in;
  logic [4:0]  ex_rd_in;
  logic [31:0] ex_result_in;
  logic        mem_valid_in, mem_rd_write_in;
  logic [4:0]  mem_rd_in;
  logic [31:0] mem_result_in;
  logic [4:0]  wb_rd_in;
  logic        wb_rd_write_in, wb_flush_in;
  logic [31:0] wb_result_in;
  logic        stall_out, valid_out, rd_write_out;
  logic [31:0] rs1_value_out, rs2_value_out;
  logic [4:0]  rd_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv32_operand_bypass #(.XLEN(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_in       (stall_in),
    .flush_in       (flush_in),
    .valid_in       (valid_in),
    .rs1_in         (rs1_in),
    .rs2_in         (rs2_in),
    .rs1_used_in    (rs1_used_in),
    .rs2_used_in    (rs2_used_in),
    .rd_in          (rd_in),
    .rd_write_in    (rd_write_in),
    .rs1_value_in   (rs1_value_in),
    .rs2_value_in   (rs2_value_in),
    .ex_valid_in    (ex_valid_in),
    .ex_rd_in       (ex_rd_in),
    .ex_rd_write_in (ex_rd_write_in),
    .ex_mem_read_in (ex_mem_read_in),
    .ex_result_in   (ex_result_in),
    .mem_valid_in   (mem_valid_in),
    .mem_rd_in      (mem_rd_in),
    .mem_rd_write_in(mem_rd_write_in),
    .mem_result_in  (mem_result_in),
    .wb_rd_in       (wb_rd_in),
    .wb_rd_write_in (wb_rd_write_in),
    .wb_flush_in    (wb_flush_in),
    .wb_result_in   (wb_result_in),
    .stall_out      (stall_out),
    .valid_out      (valid_out),
    .rs1_value_out  (rs1_value_out),
    .rs2_value_out  (rs2_value_out),
    .rd_out         (rd_out),
    .rd_write_out   (rd_write_out)
  );

  task automatic idle_inputs();
    reset = 1'b0; stall_in = 1'b0; flush_in = 1'b0; valid_in = 1'b0;
    rs1_in = 5'd0; rs2_in = 5'd0; rs1_used_in = 1'b0; rs2_used_in = 1'b0;
    rd_in = 5'd0; rd_write_in = 1'b0; rs1_value_in = 32'd0; rs2_value_in = 32'd0;
    ex_valid_in = 1'b0; ex_rd_in = 5'd0; ex_rd_write_in = 1'b0; ex_mem_read_in = 1'b0;
    ex_result_in = 32'd0;
    mem_valid_in = 1'b0; mem_rd_in = 5'd0; mem_rd_write_in = 1'b0; mem_result_in = 32'd0;
    wb_rd_in = 5'd0; wb_rd_write_in = 1'b0; wb_flush_in = 1'b0; wb_result_in = 32'd0;
  endtask

  // Advance past the next active edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (valid_out !== 1'b0 || rd_write_out !== 1'b0 || rd_out !== 5'd0 ||
        rs1_value_out !== 32'd0 || rs2_value_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b wr=%b rd=%0d rs1=%h rs2=%h, want all zero",
               valid_out, rd_write_out, rd_out, rs1_value_out, rs2_value_out);
    end
  endtask

  task automatic test_alu_dependency();
    @(negedge clk);
    idle_inputs();
    valid_in = 1'b1; rs1_in = 5'd5; rs1_used_in = 1'b1; rs1_value_in = 32'd0;
    rd_in = 5'd9; rd_write_in = 1'b1;
    ex_valid_in = 1'b1; ex_rd_in = 5'd5; ex_rd_write_in = 1'b1; ex_result_in = 32'h11;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      failures++;
      $display("FAIL alu_dep_stall: got %b want 0", stall_out);
    end
    tick();
    checks++;
    if (rs1_value_out !== 32'h11 || valid_out !== 1'b1 || rd_out !== 5'd9 ||
        rd_write_out !== 1'b1) begin
      failures++;
      $display("FAIL alu_dep_capture: got rs1=%h valid=%b rd=%0d wr=%b want 11/1/9/1",
               rs1_value_out, valid_out, rd_out, rd_write_out);
    end
  endtask

  task automatic test_priority();
    logic [31:0] want [4];
    want[0] = 32'hA; want[1] = 32'hB; want[2] = 32'hC; want[3] = 32'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      valid_in = 1'b1; rs2_in = 5'd7; rs2_used_in = 1'b1; rs2_value_in = 32'h55;
      rd_in = 5'd1; rd_write_in = 1'b1;
      ex_valid_in = 1'b1; ex_rd_write_in = 1'b1; ex_result_in = 32'hA;
      ex_rd_in = (i == 0) ? 5'd7 : 5'd8;
      mem_valid_in = (i <= 1); mem_rd_write_in = 1'b1; mem_rd_in = 5'd7; mem_result_in = 32'hB;
      wb_rd_write_in = 1'b1; wb_rd_in = 5'd7; wb_result_in = 32'hC;
      wb_flush_in = (i == 3);
      tick();
      checks++;
      if (rs2_value_out !== want[i]) begin
        failures++;
        $display("FAIL priority_case%0d: got %h want %h", i, rs2_value_out, want[i]);
      end
    end
  endtask

  task automatic test_x0_guard();
    @(negedge clk);
    idle_inputs();
    valid_in = 1'b1; rs1_in = 5'd0; rs1_used_in = 1'b1; rs1_value_in = 32'd0;
    rs2_in = 5'd0; rs2_used_in = 1'b1; rs2_value_in = 32'd0;
    ex_valid_in = 1'b1; ex_rd_in = 5'd0; ex_rd_write_in = 1'b1; ex_result_in = 32'hFFFF_FFFF;
    mem_valid_in = 1'b1; mem_rd_in = 5'd0; mem_rd_write_in = 1'b1; mem_result_in = 32'h1;
    wb_rd_in = 5'd0; wb_rd_write_in = 1'b1; wb_result_in = 32'h2;
    tick();
    checks++;
    if (rs1_value_out !== 32'd0 || rs2_value_out !== 32'd0) begin
      failures++;
      $display("FAIL x0_guard: got rs1=%h rs2=%h want 0/0", rs1_value_out, rs2_value_out);
    end
  endtask

  task automatic test_load_use();
    // Load to x3 in EX, decode reads x3 as rs1.
    @(negedge clk);
    idle_inputs();
    valid_in = 1'b1; rs1_in = 5'd3; rs1_used_in = 1'b1; rd_in = 5'd4; rd_write_in = 1'b1;
    ex_valid_in = 1'b1; ex_rd_in = 5'd3; ex_rd_write_in = 1'b1; ex_mem_read_in = 1'b1;
    ex_result_in = 32'hBAD0;
    #1;
    checks++;
    if (stall_out !== 1'b1) begin
      failures++;
      $display("FAIL load_use_stall: got %b want 1", stall_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || rd_write_out !== 1'b0) begin
      failures++;
      $display("FAIL load_use_bubble: got valid=%b wr=%b want 0/0", valid_out, rd_write_out);
    end
    // Load has moved to MEM; same instruction re-presented.
    @(negedge clk);
    ex_valid_in = 1'b0; ex_mem_read_in = 1'b0;
    mem_valid_in = 1'b1; mem_rd_in = 5'd3; mem_rd_write_in = 1'b1; mem_result_in = 32'h1234;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      failures++;
      $display("FAIL load_use_release: got stall=%b want 0", stall_out);
    end
    tick();
    checks++;
    if (rs1_value_out !== 32'h1234 || valid_out !== 1'b1 || rd_out !== 5'd4) begin
      failures++;
      $display("FAIL load_use_forward: got rs1=%h valid=%b rd=%0d want 1234/1/4",
               rs1_value_out, valid_out, rd_out);
    end
    // rs1 not actually read: no hazard.
    @(negedge clk);
    idle_inputs();
    valid_in = 1'b1; rs1_in = 5'd3; rs1_used_in = 1'b0;
    ex_valid_in = 1'b1; ex_rd_in = 5'd3; ex_rd_write_in = 1'b1; ex_mem_read_in = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      failures++;
      $display("FAIL load_use_unused: got %b want 0", stall_out);
    end
    // Hazard through rs2.
    rs2_in = 5'd3; rs2_used_in = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b1) begin
      failures++;
      $display("FAIL load_use_rs2: got %b want 1", stall_out);
    end
    // Invalid decode instruction never stalls.
    valid_in = 1'b0;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      failures++;
      $display("FAIL load_use_invalid: got %b want 0", stall_out);
    end
    // Load to x0 is not a hazard.
    valid_in = 1'b1; ex_rd_in = 5'd0; rs2_in = 5'd0;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      failures++;
      $display("FAIL load_use_x0: got %b want 0", stall_out);
    end
  endtask

  task automatic test_stall_flush();
    @(negedge clk);
    idle_inputs();
    valid_in = 1'b1; rs1_in = 5'd2; rs1_used_in = 1'b1; rs1_value_in = 32'h77;
    rd_in = 5'd4; rd_write_in = 1'b1;
    tick();
    // Stall + flush together: hold.
    @(negedge clk);
    stall_in = 1'b1; flush_in = 1'b1; rs1_value_in = 32'h99; rd_in = 5'd6;
    #1;
    checks++;
    if (stall_out !== 1'b1) begin
      failures++;
      $display("FAIL stall_passthru: got %b want 1", stall_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || rd_write_out !== 1'b1 || rs1_value_out !== 32'h77 ||
        rd_out !== 5'd4) begin
      failures++;
      $display("FAIL stall_hold: got valid=%b wr=%b rs1=%h rd=%0d want 1/1/77/4",
               valid_out, rd_write_out, rs1_value_out, rd_out);
    end
    // Flush alone squashes control but keeps data.
    @(negedge clk);
    stall_in = 1'b0;
    tick();
    checks++;
    if (valid_out !== 1'b0 || rd_write_out !== 1'b0 || rs1_value_out !== 32'h77 ||
        rd_out !== 5'd4) begin
      failures++;
      $display("FAIL flush: got valid=%b wr=%b rs1=%h rd=%0d want 0/0/77/4",
               valid_out, rd_write_out, rs1_value_out, rd_out);
    end
    // valid_in=0 gates rd_write_out.
    @(negedge clk);
    flush_in = 1'b0; valid_in = 1'b0; rd_write_in = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b0 || rd_write_out !== 1'b0 || rd_out !== 5'd6) begin
      failures++;
      $display("FAIL invalid_capture: got valid=%b wr=%b rd=%0d want 0/0/6",
               valid_out, rd_write_out, rd_out);
    end
  endtask

  task automatic test_reset_mid_hazard();
    @(negedge clk);
    idle_inputs();
    valid_in = 1'b1; rs1_value_in = 32'hDEAD; rs2_value_in = 32'hDEAD; rs1_in = 5'd1;
    rs2_in = 5'd2; rd_in = 5'd10; rd_write_in = 1'b1;
    tick();
    checks++;
    if (rs1_value_out !== 32'hDEAD || rs2_value_out !== 32'hDEAD) begin
      failures++;
      $display("FAIL pre_reset_capture: got rs1=%h rs2=%h want dead/dead",
               rs1_value_out, rs2_value_out);
    end
    @(negedge clk);
    rs1_used_in = 1'b1;
    ex_valid_in = 1'b1; ex_rd_in = 5'd1; ex_rd_write_in = 1'b1; ex_mem_read_in = 1'b1;
    stall_in = 1'b1;
    reset = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b0 || rd_write_out !== 1'b0 || rd_out !== 5'd0 ||
        rs1_value_out !== 32'd0 || rs2_value_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_hazard: got valid=%b wr=%b rd=%0d rs1=%h rs2=%h want zeros",
               valid_out, rd_write_out, rd_out, rs1_value_out, rs2_value_out);
    end
    @(negedge clk);
    idle_inputs();
    valid_in = 1'b1; rs1_in = 5'd1; rs1_value_in = 32'h42; rd_in = 5'd11; rd_write_in = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b1 || rs1_value_out !== 32'h42 || rd_out !== 5'd11 ||
        rd_write_out !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_capture: got valid=%b rs1=%h rd=%0d wr=%b want 1/42/11/1",
               valid_out, rs1_value_out, rd_out, rd_write_out);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu_dependency();
    test_priority();
    test_x0_guard();
    test_load_use();
    test_stall_flush();
    test_reset_mid_hazard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
